// File: rtl/run_ctrl_pkg.sv
// Shared types for the program-run sequencer.
// Holds the run state encoding and the phase counter width.
package run_ctrl_pkg;

  localparam int PH_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } run_state_t;

endpackage

// File: rtl/run_controller_if.sv
// Run control bundle between the system/core and run_controller.
// master: system and core side; slave: the controller.
interface run_controller_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic             halt_req;
  logic             pc_init;
  logic             core_en;
  logic             busy;
  logic             halt;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start,
    output halt_req,
    input  pc_init,
    input  core_en,
    input  busy,
    input  halt,
    input  timeout,
    input  cycle_count
  );

  modport slave (
    input  start,
    input  halt_req,
    output pc_init,
    output core_en,
    output busy,
    output halt,
    output timeout,
    output cycle_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over enable; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_controller.sv
// Program-run sequencer: IDLE -> INIT -> RUN -> DRAIN -> DONE.
// Optional RUN-cycle watchdog enabled by RUN_CTRL_WATCHDOG_EN.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int INIT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_CYCLES   = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RST_n,
  run_controller_if.slave   bus
);

  localparam logic [PH_CNT_W-1:0] INIT_LAST =
    PH_CNT_W'(INIT_CYCLES - 1);
  localparam logic [PH_CNT_W-1:0] DRAIN_LAST =
    PH_CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam bit NO_DRAIN = (DRAIN_CYCLES == 0);

  run_state_t          state_q, state_d;
  logic [PH_CNT_W-1:0] ph_q, ph_d;
  logic                to_q, to_d;
  logic                pc_init_q;
  logic                core_en_q;
  logic                busy_q;
  logic                halt_q;
  logic [CNT_W-1:0]    cnt;
  logic                wd_hit;
  logic                cnt_clr;
  logic                cnt_en;

`ifdef RUN_CTRL_WATCHDOG_EN
  assign wd_hit = (cnt == CNT_W'(MAX_CYCLES));
`else
  assign wd_hit = 1'b0;
`endif

  // A watchdog stop must not count the cycle it fires in.
  assign cnt_en  = (state_q == RUN) && !(wd_hit && !bus.halt_req);
  assign cnt_clr = (state_q == IDLE) ||
                   ((state_q == DONE) && bus.start);

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk     (CLK),
    .rst_n   (RST_n),
    .clear_i (cnt_clr),
    .en_i    (cnt_en),
    .cnt_o   (cnt)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        to_d = 1'b0;
        if (bus.start) begin
          state_d = INIT;
          ph_d    = '0;
        end
      end
      INIT: begin
        if (ph_q == INIT_LAST) begin
          state_d = RUN;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_CNT_W'(1);
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d = NO_DRAIN ? DONE : DRAIN;
          ph_d    = '0;
        end else if (wd_hit) begin
          state_d = DONE;
          to_d    = 1'b1;
        end
      end
      DRAIN: begin
        if (ph_q == DRAIN_LAST) begin
          state_d = DONE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = INIT;
          ph_d    = '0;
          to_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
        to_d    = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the next state so they track state_q.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      to_q      <= 1'b0;
      pc_init_q <= 1'b0;
      core_en_q <= 1'b0;
      busy_q    <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      to_q      <= to_d;
      pc_init_q <= (state_d == INIT);
      core_en_q <= (state_d == RUN) || (state_d == DRAIN);
      busy_q    <= (state_d == INIT) || (state_d == RUN) ||
                   (state_d == DRAIN);
      halt_q    <= (state_d == DONE);
    end
  end

  assign bus.pc_init     = pc_init_q;
  assign bus.core_en     = core_en_q;
  assign bus.busy        = busy_q;
  assign bus.halt        = halt_q;
  assign bus.timeout     = to_q;
  assign bus.cycle_count = cnt;

endmodule

// File: doc/run_controller.md
# run_controller

Sequences one program run of the processor `TopLevel`:
- Accepts the one-cycle `start` pulse.
- Holds the core in an initialisation phase (PC and register clear).
- Enables execution and counts cycles.
- On a halt instruction, lets the pipeline drain, then raises `halt` to the environment.

It sits between the testbench/system `start`/`halt` pins and the core's fetch/PC logic, replacing ad-hoc start handling in the core.

## Interface
Parameters:
- `CNT_W`, 16: width of the cycle counter.
- `INIT_CYCLES`, 2: cycles `pc_init` is held after `start`; legal range 1..15.
- `DRAIN_CYCLES`, 3: cycles between `halt_req` and `halt`; legal range 0..15.
- `MAX_CYCLES`, 16'hFFFF: watchdog limit on RUN cycles; only used when `RUN_CTRL_WATCHDOG_EN` is defined.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RST_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: run request; sampled at the rising edge.
- `halt_req`, in, 1: from the core decode; halt instruction retired this cycle.
- `pc_init`, out, 1: core PC and register-file clear.
- `core_en`, out, 1: fetch/execute enable to the core.
- `busy`, out, 1: run in progress (INIT, RUN or DRAIN).
- `halt`, out, 1: run finished; held until the next accepted `start`.
- `timeout`, out, 1: run ended by the watchdog.
- `cycle_count`, out, `CNT_W`: number of RUN cycles in the current/last run.

## Operation
- States: IDLE, INIT, RUN, DRAIN, DONE. All outputs are Moore, decoded from registered state/counters.
- Reset (`RST_n`=0, asynchronous): state=IDLE, all outputs 0, `cycle_count`=0, internal counters 0.
- IDLE:
  - `start`=1 → INIT.
  - `cycle_count` cleared, `timeout` cleared.
- INIT:
  - `pc_init`=1, `busy`=1.
  - Internal counter runs 0..`INIT_CYCLES`-1; at the last count → RUN.
  - `start` ignored.
- RUN:
  - `core_en`=1, `busy`=1.
  - `cycle_count` increments each cycle and saturates at all-ones.
  - `halt_req`=1 → DRAIN, or DONE if `DRAIN_CYCLES`=0.
- DRAIN:
  - `core_en`=1, `busy`=1.
  - Counter runs 0..`DRAIN_CYCLES`-1, then → DONE.
  - `halt_req` ignored; `cycle_count` frozen.
- DONE:
  - `halt`=1; `cycle_count` and `timeout` hold.
  - `start`=1 → INIT; `cycle_count` and `timeout` clear on that edge.
- `start` during INIT/RUN/DRAIN is ignored; no queuing.
- `halt_req` outside RUN is ignored.
- Simultaneous `halt_req` and watchdog expiry in the same RUN cycle: `halt_req` wins → DRAIN, `timeout` stays 0.
- Reset mid-run returns to IDLE immediately; the run is lost.

## Timing
- `start` high at edge k:
  - `pc_init`=1 for cycles k+1..k+`INIT_CYCLES`.
  - `core_en`=1 from cycle k+`INIT_CYCLES`+1.
- The first RUN cycle counts as 1: `cycle_count` reads 1 after the first RUN edge.
- `halt_req` high in RUN cycle at edge m:
  - `core_en` stays 1 through m+`DRAIN_CYCLES`.
  - `halt`=1 from m+`DRAIN_CYCLES`+1.
- `halt` deasserts one cycle after the edge sampling a restarting `start`, together with `pc_init` rising.
- Minimum restart interval: `start` may be re-asserted in the first DONE cycle.

## Configuration
- Macro: `RUN_CTRL_WATCHDOG_EN`.
- Defined:
  - In RUN, when `cycle_count` = `MAX_CYCLES` and `halt_req`=0, go directly to DONE with `timeout`=1 (no drain).
  - `core_en` drops the next cycle.
- Undefined:
  - No watchdog; `timeout` is tied to 0.
  - `MAX_CYCLES` is unused.
  - RUN lasts until `halt_req`.

## Structure
- Package `run_ctrl_pkg`:
  - State enum `run_state_t` (IDLE, INIT, RUN, DRAIN, DONE).
  - Phase counter width constant `PH_CNT_W`=4.
- Sub-module `sat_counter` (parameter `W`):
  - Inputs: clear, enable.
  - Saturating up-counter; used for `cycle_count`.
- The INIT/DRAIN phase counter stays inline.

## Test plan
- Reset then idle 10 cycles → all outputs 0, state IDLE.
- `start` pulse, `halt_req` after 5 RUN cycles, defaults:
  - `pc_init` high 2 cycles.
  - `core_en` high 5+3 cycles.
  - `halt`=1 with `cycle_count`=5.
- `DRAIN_CYCLES`=0, `halt_req` on the first RUN cycle → `halt` next cycle, `cycle_count`=1.
- `start` pulses during INIT and RUN → ignored; timing identical to the single-start case.
- With `RUN_CTRL_WATCHDOG_EN`, `MAX_CYCLES`=20, no `halt_req` → `halt`=1, `timeout`=1, `cycle_count`=20.
- `halt_req` and watchdog on the same cycle → `timeout`=0.
- `RST_n` pulled low mid-RUN at cycle 7 → outputs 0 asynchronously.
- Restart from DONE → `cycle_count` cleared, new run completes normally.
